fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of prefetch queue entries (power of two, 2..8).
REQ-002 Parameter RESET_PC, default 8'h00, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  8  fetch address; equals PCout while imem_req is high.
REQ-007 imem_gnt  input  1  memory accepts the request in the cycle it is high together with imem_req.
REQ-008 imem_rvalid  input  1  returned instruction valid, in order, at least 1 cycle after grant.
REQ-009 imem_rdata  input  8  returned instruction byte.
REQ-010 instr_valid  output  1  queue head holds a valid instruction for the CPU.
REQ-011 instr  output  8  queue head instruction.
REQ-012 instr_pc  output  8  address the head instruction was fetched from.
REQ-013 instr_ready  input  1  CPU consumes the head when high with instr_valid.
REQ-014 Jump  input  1  redirect strobe from CPU.
REQ-015 jump_target  input  8  redirect address, sampled when Jump is high.
REQ-016 PCout  output  8  next fetch address register.
REQ-017 count  output  4  current queue occupancy, 0..DEPTH.

Function
REQ-018 Control FSM SHALL have states IDLE, REQ, WAIT, WAIT_DISCARD; at most one memory request outstanding.
REQ-019 IDLE -> REQ when count + pending pushes < DEPTH; imem_req SHALL be high exactly in REQ.
REQ-020 In REQ, imem_addr SHALL be held stable until imem_gnt; on grant PCout <= PCout + 1 (mod 256, 8'hFF wraps to 8'h00) and FSM -> WAIT.
REQ-021 In WAIT, on imem_rvalid push {imem_rdata, fetch address} into queue; FSM -> REQ if space remains after push, else IDLE.
REQ-022 In WAIT_DISCARD, imem_rvalid SHALL be dropped (no push); FSM -> REQ.
REQ-023 imem_rvalid in IDLE or REQ SHALL be ignored.
REQ-024 instr_valid = (count != 0); instr/instr_pc reflect head entry, combinational from queue storage, no added latency.
REQ-025 Pop when instr_valid && instr_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-026 Fetch-to-visible latency: instruction returned in cycle N is at head (if queue was empty) with instr_valid high in cycle N+1.
REQ-027 Queue SHALL never overflow: requests are not issued when count = DEPTH; pops SHALL be ignored when empty.
REQ-028 Jump has priority over all other events in its cycle: queue flushed (count <= 0), PCout <= jump_target, any push that cycle discarded.
REQ-029 Jump in WAIT -> WAIT_DISCARD; Jump in REQ without grant -> REQ at jump_target (request withdrawn for that cycle's address from next cycle on).
REQ-030 Jump in REQ with simultaneous imem_gnt -> WAIT_DISCARD, PCout <= jump_target (no +1).
REQ-031 Jump in WAIT with simultaneous imem_rvalid -> data dropped, FSM -> REQ at jump_target.
REQ-032 A pop in the Jump cycle SHALL be honoured by the CPU side; the queue is still flushed.
REQ-033 All outputs SHALL be glitch-free registered state or decode of registered state, except instr/instr_pc head read.

Reset
REQ-034 reset low SHALL asynchronously clear: FSM=IDLE, PCout=RESET_PC, count=0, instr_valid=0, imem_req=0, outstanding/discard flags=0.
REQ-035 instr and instr_pc SHALL read 8'h00 while count=0 after reset.
REQ-036 Reset asserted mid-operation SHALL abandon any outstanding request; a later imem_rvalid SHALL be ignored.
REQ-037 First imem_req SHALL assert no earlier than the second rising clk edge after reset deasserts.

Verification
REQ-038 Reset release, memory grants immediately, rvalid 1 cycle later, instr_ready=0 -> addresses 00,01,02,03 fetched, count reaches 4, imem_req stays low.
REQ-039 Full queue, instr_ready=1 for one cycle -> instr=byte@00, instr_pc=00 popped, count 3, new request at 04.
REQ-040 Jump=1, jump_target=8'h40 while WAIT -> count=0 next cycle, returning data dropped, next request addr 40, next instr_pc=40.
REQ-041 Jump with simultaneous imem_gnt and with simultaneous imem_rvalid (separate runs) -> no stale entry ever appears; next instr_pc=jump_target.
REQ-042 PCout=8'hFE, continuous fetch -> instr_pc sequence FE, FF, 00, 01.
REQ-043 reset pulsed low during WAIT, stray imem_rvalid afterwards -> count=0, instr_valid=0, first new fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction prefetch queue with a single-outstanding fetch FSM
//             and jump redirect/flush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_gnt,
  input  logic       imem_rvalid,
  input  logic [7:0] imem_rdata,
  output logic       instr_valid,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  input  logic       instr_ready,
  input  logic       Jump,
  input  logic [7:0] jump_target,
  output logic [7:0] PCout,
  output logic [3:0] count
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    REQ          = 2'd1,
    WAIT         = 2'd2,
    WAIT_DISCARD = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             started;
  logic [7:0]       pc_q;
  logic [7:0]       fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [3:0]       count_q;
  logic [3:0]       count_nxt;
  logic             push;
  logic             pop;
  logic             grant;
  logic [7:0]       data_mem [DEPTH];
  logic [7:0]       pc_mem   [DEPTH];

  assign grant     = (state == REQ) && imem_gnt;
  assign push      = (state == WAIT) && imem_rvalid && !Jump;
  assign pop       = (count_q != 4'd0) && instr_ready;
  assign count_nxt = count_q + {3'b000, push} - {3'b000, pop};

  // Holds the FSM in IDLE for one extra edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) started <= 1'b0;
    else        started <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (started && (Jump || (count_q < DEPTH_C))) state_nxt = REQ;
      end
      REQ: begin
        if (imem_gnt) state_nxt = Jump ? WAIT_DISCARD : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (Jump || (count_nxt < DEPTH_C)) state_nxt = REQ;
          else                               state_nxt = IDLE;
        end else if (Jump) begin
          state_nxt = WAIT_DISCARD;
        end
      end
      WAIT_DISCARD: begin
        if (imem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      fetch_pc <= 8'h00;
    end else begin
      if (grant) fetch_pc <= pc_q;
      if (Jump)       pc_q <= jump_target;
      else if (grant) pc_q <= pc_q + 8'd1;
    end
  end

  // Jump flushes the queue regardless of any push/pop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= 4'd0;
    end else if (Jump) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc_q;
  assign PCout       = pc_q;
  assign count       = count_q;
  assign instr_valid = (count_q != 4'd0);
  assign instr       = instr_valid ? data_mem[rd_ptr] : 8'h00;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue with a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int         DEPTH    = 4;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_gnt = 1'b0;
  logic       imem_rvalid = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_ready = 1'b0;
  logic       Jump = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic [7:0] PCout;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  // Model: queue of {data, pc}, next fetch pc, and the memory's one outstanding request.
  logic [15:0] mq[$];
  logic [7:0]  model_pc = RESET_PC;
  bit          outs = 1'b0;
  bit          outs_disc = 1'b0;
  logic [7:0]  outs_addr = 8'h00;
  int          wait_cnt = 0;
  int          dir_dly = 1;
  int          gap = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .Jump       (Jump),
    .jump_target(jump_target),
    .PCout      (PCout),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [7:0] a);
    return (a * 8'd37) + 8'd91;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [15:0] h;
    h = (mq.size() > 0) ? mq[0] : 16'h0000;
    chk("count", 32'(count), 32'(mq.size()));
    chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
    chk("instr", 32'(instr), 32'(h[15:8]));
    chk("instr_pc", 32'(instr_pc), 32'(h[7:0]));
    chk("PCout", 32'(PCout), 32'(model_pc));
    if (imem_req) begin
      chk("req_addr", 32'(imem_addr), 32'(model_pc));
      chk("req_while_outstanding", 32'(outs), 32'd0);
      chk("req_with_space", 32'(mq.size() < DEPTH), 32'd1);
      gap = 0;
    end else if (!outs && mq.size() < DEPTH) begin
      gap++;
      if (gap > 4) begin
        total++;
        bad++;
        $display("FAIL liveness: no request for %0d cycles with space, required <= 4", gap);
        gap = 0;
      end
    end else begin
      gap = 0;
    end
  endtask

  // One clock cycle: check post-edge state, drive inputs, advance the model across the next edge.
  task automatic cycle(input bit rnd, input bit g, input bit r, input bit j,
                       input logic [7:0] tgt, input bit stray);
    bit rv;
    bit grant;
    bit push;
    bit pop;
    @(negedge clk);
    check_model();
    Jump        = j;
    jump_target = tgt;
    instr_ready = r;
    imem_gnt    = g;
    rv          = 1'b0;
    imem_rdata  = 8'h00;
    if (outs) begin
      if (wait_cnt <= 1) begin
        rv         = 1'b1;
        imem_rdata = mem_byte(outs_addr);
      end else begin
        wait_cnt--;
      end
    end else if (stray) begin
      rv         = 1'b1;
      imem_rdata = 8'($urandom);
    end
    imem_rvalid = rv;
    grant = imem_req && g;
    pop   = r && (mq.size() > 0);
    push  = rv && outs && !outs_disc && !j;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back({mem_byte(outs_addr), outs_addr});
    if (rv && outs) outs = 1'b0;
    if (grant) begin
      outs      = 1'b1;
      outs_disc = 1'b0;
      outs_addr = model_pc;
      wait_cnt  = rnd ? int'($urandom_range(1, 3)) : dir_dly;
      model_pc  = model_pc + 8'd1;
    end
    if (j) begin
      mq.delete();
      model_pc = tgt;
      if (outs) outs_disc = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    Jump        = 1'b0;
    instr_ready = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 8'h00;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mq.delete();
    model_pc  = RESET_PC;
    outs      = 1'b0;
    outs_disc = 1'b0;
    gap       = 0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_pc", 32'(PCout), 32'(RESET_PC));
    chk("rst_req", 32'(imem_req), 32'd0);
  endtask

  task automatic wait_req();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      seen = imem_req;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_req: imem_req=0 after 10 cycles, required 1");
    end
  endtask

  initial begin
    logic [7:0] wrap_seq [4];
    wrap_seq[0] = 8'hFE;
    wrap_seq[1] = 8'hFF;
    wrap_seq[2] = 8'h00;
    wrap_seq[3] = 8'h01;

    do_reset();

    // Bring-up: request no earlier than the second edge, then fill the queue.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("req_after_edge1", 32'(imem_req), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'(RESET_PC));
    repeat (16) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_req_low", 32'(imem_req), 32'd0);
    chk("fill_head_pc", 32'(instr_pc), 32'h00);
    chk("fill_head", 32'(instr), 32'(mem_byte(8'h00)));
    chk("fill_pc", 32'(PCout), 32'h04);

    // Single pop from a full queue, then refetch at 04.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pop_count", 32'(count), 32'd3);
    chk("pop_head_pc", 32'(instr_pc), 32'h01);
    dir_dly = 2;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", 32'(imem_addr), 32'h04);

    // Jump while waiting for data.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("jwait_count", 32'(count), 32'd0);
    chk("jwait_valid", 32'(instr_valid), 32'd0);
    dir_dly = 1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("jwait_req", 32'(imem_req), 32'd1);
    chk("jwait_addr", 32'(imem_addr), 32'h40);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("jwait_head_pc", 32'(instr_pc), 32'h40);
    chk("jwait_head", 32'(instr), 32'(mem_byte(8'h40)));

    // Jump together with a grant.
    wait_req();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("jgnt_head_pc", 32'(instr_pc), 32'h80);
    chk("jgnt_head", 32'(instr), 32'(mem_byte(8'h80)));

    // Jump together with returning data.
    wait_req();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("jrv_head_pc", 32'(instr_pc), 32'hC0);

    // Address wrap FE, FF, 00, 01.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0);
    repeat (16) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_pc", 32'(instr_pc), 32'(wrap_seq[k]));
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    end

    // Reset during WAIT followed by a stray response.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
    wait_req();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("mrst_req", 32'(imem_req), 32'd1);
    chk("mrst_addr", 32'(imem_addr), 32'(RESET_PC));
    chk("mrst_count2", 32'(count), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      cycle(1'b1, ($urandom % 4) != 0, ($urandom % 2) != 0, ($urandom % 24) == 0,
            8'($urandom), ($urandom % 6) == 0);
    end
    @(negedge clk);
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
